// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the fetch unit.
//   word_t        : 32-bit machine word
//   ramstate_t    : instruction memory status (FREE, BUSY, ACCESS, ERROR)
//   opcode_t      : opcode field [6:0] values the fetch unit cares about
//   fetch_state_t : fetch unit FSM states (FETCH, HALTED, ERR)
//   RESET_PC_DEFAULT : default PC loaded on reset
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [6:0] {
        OP_IMM = 7'h13,
        HALT   = 7'h7F
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        ERR    = 2'd2
    } fetch_state_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a one-entry output register towards decode.
// Issues a read at PC whenever the output slot is free (or being drained
// this cycle) and no redirect is pending; captures data on ACCESS.
//
// Optional feature: define FETCH_MISALIGN_CHECK_EN to turn misaligned
// redirect targets into a sticky fault instead of silently aligning them.
//
// Ports:
//   CLK, RST        : clock, synchronous active-high reset
//   iREN, iaddr     : instruction memory read request and address (PC)
//   iload, ramstate : instruction data and memory status
//   out_valid/out_ready/out_instr/out_pc : handshake towards decode
//   redirect_valid, redirect_pc : branch/jump redirect
//   halted, fetch_error : status (HALT opcode seen, sticky fault)
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic      CLK,
    input  logic      RST,
    output logic      iREN,
    output word_t     iaddr,
    input  word_t     iload,
    input  ramstate_t ramstate,
    output logic      out_valid,
    input  logic      out_ready,
    output word_t     out_instr,
    output word_t     out_pc,
    input  logic      redirect_valid,
    input  word_t     redirect_pc,
    output logic      halted,
    output logic      fetch_error
);

    fetch_state_t state;
    word_t        pc;
    word_t        pc_plus4;
    word_t        redirect_aligned;
    logic         misaligned;
    logic         capture;
    logic         mem_fault;
    logic         drained;

    assign iaddr            = pc;
    assign pc_plus4         = pc + 32'd4;          // wraps naturally at 2^32
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign misaligned = |redirect_pc[1:0];
`else
    assign misaligned = 1'b0;
`endif

    // Request only when the output slot frees up this cycle; a redirect
    // suppresses the request because the data would be thrown away.
    assign iREN      = (state == FETCH) && (!out_valid || out_ready) && !redirect_valid;
    assign capture   = iREN && (ramstate == ACCESS);
    assign mem_fault = iREN && (ramstate == ERROR);
    assign drained   = out_valid && out_ready;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_pc      <= '0;
            halted      <= 1'b0;
            fetch_error <= 1'b0;
        end else if (state == ERR) begin
            // Frozen until reset; decode may still drain what it holds.
            if (drained)
                out_valid <= 1'b0;
        end else if (redirect_valid) begin
            out_valid <= 1'b0;
            halted    <= 1'b0;
            if (misaligned) begin
                state       <= ERR;
                fetch_error <= 1'b1;
            end else begin
                state <= FETCH;
                pc    <= redirect_aligned;
            end
        end else if (capture) begin
            out_instr <= iload;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= pc_plus4;
            // HALT is still handed to decode; fetching stops after it.
            if (iload[6:0] == HALT) begin
                state  <= HALTED;
                halted <= 1'b1;
            end
        end else begin
            if (drained)
                out_valid <= 1'b0;
            if (mem_fault) begin
                state       <= ERR;
                fetch_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t RPC = 32'h0000_0000;

    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      iREN;
    word_t     iaddr;
    word_t     iload = '0;
    ramstate_t ramstate = FREE;
    logic      out_valid;
    logic      out_ready = 1'b0;
    word_t     out_instr;
    word_t     out_pc;
    logic      redirect_valid = 1'b0;
    word_t     redirect_pc = '0;
    logic      halted;
    logic      fetch_error;

    int tests = 0;
    int fails = 0;
    bit armed = 0;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit CHECK_MISALIGN = 1'b1;
`else
    localparam bit CHECK_MISALIGN = 1'b0;
`endif

    // Reference model: mode 0 = fetching, 1 = halted, 2 = faulted
    int    m_mode  = 0;
    word_t m_pc    = '0;
    bit    m_valid = 0;
    word_t m_instr = '0;
    word_t m_opc   = '0;
    bit    m_halt  = 0;
    bit    m_err   = 0;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iload(iload),
        .ramstate(ramstate), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halted(halted), .fetch_error(fetch_error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic word_t addi(input int unsigned r);
        return {r[11:0], r[16:12], 3'b000, r[21:17], 7'h13};
    endfunction

    // One clock: drive at negedge, check outputs, then advance the model
    // through the rising edge using the same inputs.
    task automatic step(input bit r, input logic [1:0] rs, input word_t ld,
                        input bit rdy, input bit rv, input word_t rp);
        bit ren;
        @(negedge CLK);
        RST = r; ramstate = ramstate_t'(rs); iload = ld;
        out_ready = rdy; redirect_valid = rv; redirect_pc = rp;
        #1;
        ren = (m_mode == 0) && (!m_valid || rdy) && !rv;
        if (armed) begin
            chk("iaddr",       iaddr, m_pc);
            chk("iREN",        {31'b0, iREN}, {31'b0, ren});
            chk("out_valid",   {31'b0, out_valid}, {31'b0, m_valid});
            chk("out_instr",   out_instr, m_instr);
            chk("out_pc",      out_pc, m_opc);
            chk("halted",      {31'b0, halted}, {31'b0, m_halt});
            chk("fetch_error", {31'b0, fetch_error}, {31'b0, m_err});
        end
        @(posedge CLK);
        if (r) begin
            m_mode = 0; m_pc = RPC; m_valid = 0; m_instr = 0; m_opc = 0;
            m_halt = 0; m_err = 0;
            armed = 1;
        end else if (m_mode == 2) begin
            if (m_valid && rdy) m_valid = 0;
        end else if (rv) begin
            m_valid = 0; m_halt = 0;
            if (CHECK_MISALIGN && rp[1:0] != 2'b00) begin
                m_mode = 2; m_err = 1;
            end else begin
                m_mode = 0; m_pc = {rp[31:2], 2'b00};
            end
        end else if (ren && rs == 2'd2) begin
            m_instr = ld; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
            if (ld[6:0] == 7'h7F) begin m_mode = 1; m_halt = 1; end
        end else begin
            if (m_valid && rdy) m_valid = 0;
            if (ren && rs == 2'd3) begin m_mode = 2; m_err = 1; end
        end
    endtask

    initial begin
        // Reset, then straight-line fetching at full throughput
        step(1, 2'd2, addi(1), 1, 0, 0);
        step(1, 2'd2, addi(2), 1, 0, 0);
        #2 chk("reset_iaddr", iaddr, RPC);
        for (int i = 0; i < 6; i++) step(0, 2'd2, addi(i + 10), 1, 0, 0);
        #2 chk("stream_iaddr", iaddr, RPC + 32'd24);

        // Back-pressure: output held, no requests
        for (int i = 0; i < 3; i++) step(0, 2'd2, addi(i + 40), 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 2'd1, addi(0), 0, 0, 0);
        step(0, 2'd2, addi(50), 1, 0, 0);
        step(0, 2'd0, addi(51), 1, 0, 0);

        // Redirect wins over same-cycle ACCESS
        step(0, 2'd0, 0, 1, 1, 32'h40);
        step(0, 2'd2, addi(60), 1, 1, 32'h100);
        #2 chk("redir_iaddr", iaddr, 32'h100);
        chk("redir_valid", {31'b0, out_valid}, 32'd0);
        step(0, 2'd2, addi(61), 1, 0, 0);

        // HALT at 0x8, then redirect out of HALTED
        step(0, 2'd0, 0, 1, 1, 32'h8);
        step(0, 2'd2, 32'h0000_007F, 1, 0, 0);
        #2 chk("halt_flag", {31'b0, halted}, 32'd1);
        chk("halt_pc", out_pc, 32'h8);
        for (int i = 0; i < 3; i++) step(0, 2'd2, addi(70), 0, 0, 0);
        step(0, 2'd2, addi(71), 1, 1, 32'h20);
        step(0, 2'd2, addi(72), 1, 0, 0);

        // Memory fault at 0xC, sticky until reset
        step(0, 2'd0, 0, 1, 1, 32'hC);
        step(0, 2'd3, addi(80), 1, 0, 0);
        #2 chk("err_flag", {31'b0, fetch_error}, 32'd1);
        for (int i = 0; i < 3; i++) step(0, 2'd2, addi(81), 1, i == 1, 32'h200);
        step(1, 2'd2, addi(82), 1, 0, 0);
        #2 chk("err_reset", {31'b0, fetch_error}, 32'd0);
        chk("err_reset_iaddr", iaddr, RPC);

        // PC wrap and misaligned redirect
        step(0, 2'd0, 0, 1, 1, 32'hFFFF_FFFC);
        step(0, 2'd2, addi(90), 1, 0, 0);
        #2 chk("wrap_iaddr", iaddr, 32'h0);
        step(0, 2'd0, 0, 1, 1, 32'h102);
        #2 chk("misalign_err", {31'b0, fetch_error}, {31'b0, CHECK_MISALIGN});
        if (!CHECK_MISALIGN) chk("misalign_iaddr", iaddr, 32'h100);
        step(0, 2'd2, addi(91), 1, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int unsigned p;
            logic [1:0] rs;
            word_t ld, rp;
            p  = $urandom_range(99);
            rs = (p < 50) ? 2'd2 : (p < 72) ? 2'd1 : (p < 97) ? 2'd0 : 2'd3;
            ld = ($urandom_range(14) == 0) ? {$urandom, 7'h7F} : addi($urandom);
            rp = $urandom;
            if ($urandom_range(1) == 0) rp[1:0] = 2'b00;
            step($urandom_range(59) == 0, rs, ld, $urandom_range(9) < 7,
                 $urandom_range(11) == 0, rp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC loaded on reset.
REQ-002 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  in  1  reset; synchronous and active-high.
REQ-004 SHALL have port iREN  out  1  instruction memory read request.
REQ-005 SHALL have port iaddr  out  word_t  instruction fetch address (current PC).
REQ-006 SHALL have port iload  in  word_t  instruction data from memory.
REQ-007 SHALL have port ramstate  in  ramstate_t  memory status; ACCESS = iload valid this cycle, BUSY = wait, ERROR = fault, FREE = idle.
REQ-008 SHALL have port out_valid  out  1  out_instr/out_pc hold an instruction for decode.
REQ-009 SHALL have port out_ready  in  1  decode accepts the held instruction this cycle.
REQ-010 SHALL have port out_instr  out  word_t  fetched instruction.
REQ-011 SHALL have port out_pc  out  word_t  address of out_instr.
REQ-012 SHALL have port redirect_valid  in  1  branch/jump redirect request.
REQ-013 SHALL have port redirect_pc  in  word_t  redirect target.
REQ-014 SHALL have port halted  out  1  fetch stopped on HALT opcode.
REQ-015 SHALL have port fetch_error  out  1  sticky memory or alignment fault.

Function
REQ-016 SHALL implement FSM of type fetch_state_t with states FETCH, HALTED, ERR.
REQ-017 SHALL drive iaddr = PC register combinationally in every state.
REQ-018 SHALL assert iREN in FETCH only when (!out_valid || out_ready) and !redirect_valid; iREN SHALL be 0 in HALTED and ERR.
REQ-019 SHALL, in FETCH with iREN=1 and ramstate==ACCESS, load out_instr<=iload, out_pc<=PC, out_valid<=1, PC<=PC+4 on the next edge.
REQ-020 SHALL clear out_valid on out_valid && out_ready unless a new instruction is captured in the same cycle (sustained throughput of one instruction per cycle).
REQ-021 SHALL hold PC, out_instr, out_pc unchanged while ramstate is BUSY or FREE.
REQ-022 SHALL compute PC+4 modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-023 SHALL, when a captured iload has opcode field [6:0]==HALT, still present it on the output and move to HALTED; halted=1 in HALTED.
REQ-024 SHALL, on ramstate==ERROR while iREN=1, discard the data, move to ERR and set fetch_error=1; ERR exits only on RST.
REQ-025 SHALL give redirect_valid priority over every event except RST and ERR: next edge PC<=redirect_pc, out_valid<=0, same-cycle ACCESS data discarded, state<=FETCH (including exit from HALTED).
REQ-026 SHALL ignore out_ready when out_valid=0.

Reset
REQ-027 SHALL, while RST=1 at an edge, set PC<=RESET_PC, state<=FETCH, out_valid<=0, out_instr<=0, out_pc<=0, halted<=0, fetch_error<=0.
REQ-028 SHALL, if RST asserts with a request in flight, drop that request; first post-reset request SHALL address RESET_PC.

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_CHECK_EN defined, treat redirect_valid with redirect_pc[1:0]!=0 as a fault: state<=ERR, fetch_error<=1, PC unchanged.
REQ-030 SHALL, without FETCH_MISALIGN_CHECK_EN, load PC<={redirect_pc[31:2],2'b00} and never fault on alignment.

Structure
REQ-031 SHALL place fetch_state_t enum and a RESET_PC default constant in cpu_types_pkg; reuse word_t, ramstate_t, opcode_t from it.
REQ-032 SHALL be a single module with no sub-module.

Verification
REQ-033 Reset, ramstate=ACCESS every cycle, out_ready=1, iload=ADDI words -> iaddr 0,4,8,...; out_pc follows one cycle later; one instruction per cycle.
REQ-034 out_valid=1, out_ready=0 for 3 cycles -> iREN=0, out_instr/out_pc stable; out_ready=1 -> iREN=1 same cycle, next fetch at out_pc+4.
REQ-035 PC=0x40, ramstate=ACCESS with redirect_valid=1, redirect_pc=0x100 same cycle -> data discarded, out_valid=0, next iaddr=0x100.
REQ-036 iload=32'h0000007F (opcode HALT) at PC=0x8 -> out_instr=0x7F, out_pc=0x8, halted=1, iREN=0; later redirect to 0x20 -> FETCH at 0x20, halted=0.
REQ-037 ramstate=ERROR during request at PC=0xC -> fetch_error=1, iREN=0 permanently; RST -> fetch_error=0, iaddr=RESET_PC.
REQ-038 PC=32'hFFFFFFFC fetched -> next iaddr=0; with FETCH_MISALIGN_CHECK_EN, redirect_pc=0x102 -> ERR; without it -> iaddr=0x100.
